fdown_sequencer: RTL and testbench

- Controller that sequences the near-IQ downconverter.
- Generates the mod2 phase signal that drives LO reordering, aligned to the ADC trigger.
- Supervises the downconverter's time_err flag, with fault/resync handling.
- De-interleaves the downconverter's I/Q output stream into registered I/Q pairs with a valid strobe.
- Sits between ADC framing logic, the downconverter and downstream feedback/readout.

---
 rtl/fdown_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fdown_sequencer.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdown_sequencer.sv
// Near-IQ downconverter sequencer: mod2 phase generation, time_err supervision, I/Q pairing.
// Optional pair averaging is enabled by defining FDOWN_SEQ_DECIM_EN.
module fdown_sequencer #(
  parameter int GUARD     = 8,
  parameter int ERR_LIM   = 4,
  parameter int HOLD      = 16,
  parameter int LOG_DECIM = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        a_gate,
  input  logic        a_trig,
  output logic        mod2,
  input  logic        time_err,
  input  logic [15:0] o_data,
  input  logic        o_trig,
  output logic [15:0] i_out,
  output logic [15:0] q_out,
  output logic        iq_valid,
  output logic        locked,
  output logic [1:0]  state,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARM   = 2'b01,
    RUN   = 2'b10,
    FAULT = 2'b11
  } st_t;

  localparam int GW = $clog2(GUARD + 2);

  if (GUARD < 0 || ERR_LIM < 1 || ERR_LIM > 255 || HOLD < 1 || HOLD > 255 || LOG_DECIM < 0)
  begin : g_param_check
    $error("fdown_sequencer: parameter out of legal range");
  end

  st_t st, st_n;
  logic [GW-1:0]      guard_cnt;
  logic [7:0]         consec;
  logic [7:0]         hold_cnt;
  logic               post;
  logic               err_hit;
  logic               pair_en;
  logic               pair_fire;
  logic               mod2_n;
  logic               pend;
  logic signed [15:0] pend_i;

  assign post      = (st == RUN) && (guard_cnt == GW'(GUARD));
  assign locked    = post;
  assign state     = st;
  assign err_hit   = post && time_err && (consec == 8'(ERR_LIM - 1));
  assign pair_en   = post && enable;
  assign pair_fire = pair_en && o_trig && pend;

  always_comb begin
    st_n = st;
    case (st)
      IDLE:    if (enable) st_n = ARM;
      ARM:     if (!enable) st_n = IDLE;
               else if (a_trig && a_gate) st_n = RUN;
      RUN:     if (!enable) st_n = IDLE;
               else if (err_hit) st_n = FAULT;
      FAULT:   if (!enable) st_n = IDLE;
               else if (hold_cnt == 8'(HOLD - 1)) st_n = ARM;
      default: st_n = IDLE;
    endcase
    // first RUN cycle always starts the phase at 1, then alternates
    mod2_n = 1'b0;
    if (st_n == RUN) mod2_n = (st == RUN) ? ~mod2 : 1'b1;
  end

`ifdef FDOWN_SEQ_DECIM_EN
  localparam int AW = 16 + LOG_DECIM;
  localparam int CW = (LOG_DECIM > 0) ? LOG_DECIM : 1;

  logic signed [AW-1:0] acc_i, acc_q;
  logic signed [AW-1:0] sum_i, sum_q;
  logic [CW-1:0]        pair_cnt;
  logic                 group_done;

  always_comb begin
    sum_i      = acc_i + AW'(pend_i);
    sum_q      = acc_q + AW'($signed(o_data));
    group_done = (pair_cnt == CW'((1 << LOG_DECIM) - 1));
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= IDLE;
      mod2      <= 1'b0;
      guard_cnt <= '0;
      consec    <= '0;
      hold_cnt  <= '0;
      err_count <= '0;
      pend      <= 1'b0;
      pend_i    <= '0;
      i_out     <= '0;
      q_out     <= '0;
      iq_valid  <= 1'b0;
`ifdef FDOWN_SEQ_DECIM_EN
      acc_i     <= '0;
      acc_q     <= '0;
      pair_cnt  <= '0;
`endif
    end else begin
      st       <= st_n;
      mod2     <= mod2_n;
      iq_valid <= 1'b0;

      if (st != RUN)  guard_cnt <= '0;
      else if (!post) guard_cnt <= guard_cnt + GW'(1);

      hold_cnt <= (st == FAULT) ? hold_cnt + 8'd1 : '0;

      if (st == IDLE && enable)
        err_count <= '0;
      else if (post && time_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;

      if (st != RUN) consec <= '0;
      else if (post) consec <= time_err ? consec + 8'd1 : '0;

      // pending I and accumulators only matter inside RUN; wipe them anywhere else
      if (st != RUN) begin
        pend <= 1'b0;
`ifdef FDOWN_SEQ_DECIM_EN
        acc_i    <= '0;
        acc_q    <= '0;
        pair_cnt <= '0;
`endif
      end else if (pair_en) begin
        if (!o_trig) begin
          pend   <= 1'b1;
          pend_i <= o_data;
        end else if (pend) begin
          pend <= 1'b0;
        end
      end

      if (pair_fire) begin
`ifdef FDOWN_SEQ_DECIM_EN
        if (group_done) begin
          i_out    <= 16'(sum_i >>> LOG_DECIM);
          q_out    <= 16'(sum_q >>> LOG_DECIM);
          iq_valid <= 1'b1;
          acc_i    <= '0;
          acc_q    <= '0;
          pair_cnt <= '0;
        end else begin
          acc_i    <= sum_i;
          acc_q    <= sum_q;
          pair_cnt <= pair_cnt + CW'(1);
        end
`else
        i_out    <= pend_i;
        q_out    <= o_data;
        iq_valid <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fdown_sequencer.sv
// Self-checking bench for fdown_sequencer: directed scenarios plus randomized run against a rule-level model.
module tb_fdown_sequencer;

  localparam int GUARD     = 8;
  localparam int ERR_LIM   = 4;
  localparam int HOLD      = 16;
  localparam int LOG_DECIM = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        a_gate = 1'b0;
  logic        a_trig = 1'b0;
  logic        time_err = 1'b0;
  logic [15:0] o_data = '0;
  logic        o_trig = 1'b0;
  logic        mod2;
  logic [15:0] i_out;
  logic [15:0] q_out;
  logic        iq_valid;
  logic        locked;
  logic [1:0]  state;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;

  fdown_sequencer #(
    .GUARD(GUARD),
    .ERR_LIM(ERR_LIM),
    .HOLD(HOLD),
    .LOG_DECIM(LOG_DECIM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .a_gate(a_gate),
    .a_trig(a_trig),
    .mod2(mod2),
    .time_err(time_err),
    .o_data(o_data),
    .o_trig(o_trig),
    .i_out(i_out),
    .q_out(q_out),
    .iq_valid(iq_valid),
    .locked(locked),
    .state(state),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference model: state as 0..3, RUN tracked as elapsed RUN cycles, FAULT as elapsed FAULT cycles.
  int                 m_state = 0;
  int                 m_run = 0;
  int                 m_fcyc = 0;
  int                 m_consec = 0;
  int                 m_err = 0;
  bit                 m_pend = 0;
  logic signed [15:0] m_pi = '0;
  logic signed [15:0] m_i = '0;
  logic signed [15:0] m_q = '0;
  bit                 m_valid = 0;
  int                 qi[$];
  int                 qq[$];

  function automatic bit m_mod2();
    return (m_state == 2) && (m_run % 2 == 0);
  endfunction

  function automatic bit m_locked();
    return (m_state == 2) && (m_run >= GUARD);
  endfunction

  task automatic model_pair(input logic signed [15:0] iv, input logic signed [15:0] qv);
`ifdef FDOWN_SEQ_DECIM_EN
    int si, sq;
    qi.push_back(int'(iv));
    qq.push_back(int'(qv));
    if (qi.size() == (1 << LOG_DECIM)) begin
      si = 0;
      sq = 0;
      foreach (qi[k]) begin
        si += qi[k];
        sq += qq[k];
      end
      m_i = 16'(si >>> LOG_DECIM);
      m_q = 16'(sq >>> LOG_DECIM);
      m_valid = 1;
      qi.delete();
      qq.delete();
    end
`else
    m_i = iv;
    m_q = qv;
    m_valid = 1;
`endif
  endtask

  task automatic model_step();
    int  ns;
    bit  post;
    ns = m_state;
    m_valid = 0;
    if (!rst_n) begin
      m_state = 0; m_run = 0; m_fcyc = 0; m_consec = 0; m_err = 0;
      m_pend = 0; m_pi = '0; m_i = '0; m_q = '0;
      qi.delete(); qq.delete();
      return;
    end
    case (m_state)
      0: if (enable) begin ns = 1; m_err = 0; end
      1: if (!enable) ns = 0; else if (a_trig && a_gate) ns = 2;
      2: begin
        post = (m_run >= GUARD);
        if (post) begin
          if (time_err) begin
            if (m_err < 255) m_err++;
            m_consec++;
          end else m_consec = 0;
        end
        if (post && enable) begin
          if (!o_trig) begin
            m_pend = 1;
            m_pi = o_data;
          end else if (m_pend) begin
            m_pend = 0;
            model_pair(m_pi, o_data);
          end
        end
        if (!enable) ns = 0;
        else if (post && m_consec >= ERR_LIM) ns = 3;
        m_run++;
      end
      default: begin
        m_fcyc++;
        if (!enable) ns = 0;
        else if (m_fcyc >= HOLD) ns = 1;
      end
    endcase
    if (ns != 2) begin
      m_run = 0; m_consec = 0; m_pend = 0;
      qi.delete(); qq.delete();
    end
    if (ns != 3) m_fcyc = 0;
    m_state = ns;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_locked();
    a_gate = 1'b1;
    a_trig = 1'b1;
    tick();
    a_trig = 1'b0;
    repeat (GUARD) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    repeat (2) tick();
    checks++;
    if (state !== 2'b00 || mod2 !== 1'b0 || locked !== 1'b0 || iq_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: state=%b mod2=%b locked=%b iq_valid=%b, want 00 0 0 0",
               state, mod2, locked, iq_valid);
    end
    checks++;
    if (i_out !== 16'd0 || q_out !== 16'd0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_data: i=%0d q=%0d err=%0d, want 0 0 0", i_out, q_out, err_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_arm_lock();
    a_gate = 1'b1;
    a_trig = 1'b0;
    tick();
    checks++;
    if (state !== 2'b01) begin
      failures++;
      $display("FAIL arm_entry: state=%b want 01", state);
    end
    repeat (8) tick();
    a_gate = 1'b0;
    a_trig = 1'b1;
    tick();
    checks++;
    if (state !== 2'b01 || mod2 !== 1'b0) begin
      failures++;
      $display("FAIL trig_no_gate: state=%b mod2=%b want 01 0", state, mod2);
    end
    a_gate = 1'b1;
    tick();
    a_trig = 1'b0;
    checks++;
    if (state !== 2'b10 || mod2 !== 1'b1 || locked !== 1'b0) begin
      failures++;
      $display("FAIL run_entry: state=%b mod2=%b locked=%b want 10 1 0", state, mod2, locked);
    end
    for (int k = 1; k <= GUARD + 2; k++) begin
      if (k == 3) a_trig = 1'b1;
      tick();
      a_trig = 1'b0;
      checks++;
      if (mod2 !== ((k % 2) == 0) || locked !== (k >= GUARD) || state !== 2'b10) begin
        failures++;
        $display("FAIL run_phase k=%0d: mod2=%b locked=%b state=%b want %b %b 10",
                 k, mod2, locked, state, (k % 2) == 0, k >= GUARD);
      end
    end
  endtask

`ifndef FDOWN_SEQ_DECIM_EN
  task automatic test_pairing();
    logic [15:0] ei, eq;
    o_trig = 1'b0; o_data = 16'd100;
    tick();
    checks++;
    if (iq_valid !== 1'b0) begin
      failures++;
      $display("FAIL pair_i_only: iq_valid=%b want 0", iq_valid);
    end
    o_trig = 1'b1; o_data = -16'sd200;
    tick();
    ei = 16'd100; eq = -16'sd200;
    checks++;
    if (iq_valid !== 1'b1 || i_out !== ei || q_out !== eq) begin
      failures++;
      $display("FAIL pair_basic: v=%b i=%0d q=%0d want 1 100 -200",
               iq_valid, $signed(i_out), $signed(q_out));
    end
    o_trig = 1'b1; o_data = 16'd9999;
    tick();
    checks++;
    if (iq_valid !== 1'b0 || i_out !== ei || q_out !== eq) begin
      failures++;
      $display("FAIL pair_drop_hold: v=%b i=%0d q=%0d want 0 100 -200",
               iq_valid, $signed(i_out), $signed(q_out));
    end
    o_trig = 1'b0; o_data = 16'd5; tick();
    o_data = 16'd7; tick();
    o_trig = 1'b1; o_data = 16'd9; tick();
    o_trig = 1'b0; o_data = 16'd0;
    checks++;
    if (iq_valid !== 1'b1 || i_out !== 16'd7 || q_out !== 16'd9) begin
      failures++;
      $display("FAIL pair_overwrite: v=%b i=%0d q=%0d want 1 7 9", iq_valid, i_out, q_out);
    end
    o_trig = 1'b1;
    tick();
    o_trig = 1'b0;
  endtask
`else
  task automatic test_decim();
    int iv[4] = '{10, 20, 30, 41};
    logic [15:0] eq;
    eq = -16'sd4;
    for (int k = 0; k < 4; k++) begin
      o_trig = 1'b0; o_data = 16'(iv[k]);
      tick();
      o_trig = 1'b1; o_data = eq;
      tick();
      checks++;
      if (iq_valid !== (k == 3)) begin
        failures++;
        $display("FAIL decim_strobe k=%0d: iq_valid=%b want %b", k, iq_valid, k == 3);
      end
    end
    o_trig = 1'b1;
    checks++;
    if (i_out !== 16'd25 || q_out !== eq) begin
      failures++;
      $display("FAIL decim_value: i=%0d q=%0d want 25 -4", $signed(i_out), $signed(q_out));
    end
    tick();
    o_trig = 1'b0;
  endtask
`endif

  task automatic test_fault();
    bit pat[12] = '{1, 0, 1, 1, 1, 0, 1, 0, 1, 1, 1, 0};
    time_err = 1'b1;
    for (int k = 1; k <= ERR_LIM; k++) begin
      tick();
      checks++;
      if (state !== ((k == ERR_LIM) ? 2'b11 : 2'b10) || err_count !== 8'(k)) begin
        failures++;
        $display("FAIL fault_entry k=%0d: state=%b err=%0d", k, state, err_count);
      end
    end
    time_err = 1'b0;
    for (int k = 1; k <= HOLD; k++) begin
      checks++;
      if (mod2 !== 1'b0 || locked !== 1'b0 || state !== 2'b11) begin
        failures++;
        $display("FAIL fault_hold k=%0d: state=%b mod2=%b locked=%b want 11 0 0",
                 k, state, mod2, locked);
      end
      tick();
    end
    checks++;
    if (state !== 2'b01 || err_count !== 8'd4) begin
      failures++;
      $display("FAIL fault_rearm: state=%b err=%0d want 01 4", state, err_count);
    end
    enter_locked();
    foreach (pat[k]) begin
      time_err = pat[k];
      tick();
      checks++;
      if (state !== 2'b10) begin
        failures++;
        $display("FAIL isolated_err k=%0d: state=%b want 10", k, state);
      end
    end
    time_err = 1'b0;
    checks++;
    if (err_count !== 8'd12) begin
      failures++;
      $display("FAIL isolated_count: err=%0d want 12", err_count);
    end
  endtask

  task automatic test_abort();
    o_trig = 1'b0; o_data = 16'd55;
    tick();
    enable = 1'b0; o_trig = 1'b1; o_data = 16'd66;
    tick();
    checks++;
    if (state !== 2'b00 || mod2 !== 1'b0 || locked !== 1'b0 || iq_valid !== 1'b0 || err_count !== 8'd12) begin
      failures++;
      $display("FAIL abort: state=%b mod2=%b locked=%b v=%b err=%0d want 00 0 0 0 12",
               state, mod2, locked, iq_valid, err_count);
    end
    enable = 1'b1; o_trig = 1'b0;
    tick();
    checks++;
    if (state !== 2'b01 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL reenable: state=%b err=%0d want 01 0", state, err_count);
    end
    enter_locked();
    o_trig = 1'b1; o_data = 16'd77;
    tick();
    o_trig = 1'b0;
    checks++;
    if (iq_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_pending_discard: iq_valid=%b want 0", iq_valid);
    end
  endtask

  task automatic test_guard();
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    a_trig = 1'b1; a_gate = 1'b1;
    tick();
    a_trig = 1'b0;
    time_err = 1'b1;
    repeat (GUARD) tick();
    checks++;
    if (err_count !== 8'd0 || state !== 2'b10 || locked !== 1'b1) begin
      failures++;
      $display("FAIL guard_ignore: err=%0d state=%b locked=%b want 0 10 1", err_count, state, locked);
    end
    tick();
    time_err = 1'b0;
    checks++;
    if (err_count !== 8'd1) begin
      failures++;
      $display("FAIL guard_first_post: err=%0d want 1", err_count);
    end
  endtask

  task automatic test_random();
    int burst;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    burst = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 59) == 0) burst = $urandom_range(0, 2);
      rst_n    = ($urandom_range(0, 499) != 0);
      enable   = ($urandom_range(0, 99) >= 3);
      a_gate   = ($urandom_range(0, 9) < 7);
      a_trig   = ($urandom_range(0, 9) == 0);
      time_err = (burst == 0) ? 1'b0 :
                 (burst == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) < 9);
      o_trig   = $urandom_range(0, 1);
      o_data   = 16'($urandom);
      tick();
      checks++;
      if (state !== 2'(m_state) || mod2 !== m_mod2() || locked !== m_locked()) begin
        failures++;
        $display("FAIL rand_ctl n=%0d: state=%b mod2=%b locked=%b want %0d %b %b",
                 n, state, mod2, locked, m_state, m_mod2(), m_locked());
      end
      checks++;
      if (err_count !== 8'(m_err) || iq_valid !== m_valid) begin
        failures++;
        $display("FAIL rand_err_valid n=%0d: err=%0d v=%b want %0d %b",
                 n, err_count, iq_valid, m_err, m_valid);
      end
      checks++;
      if (i_out !== m_i || q_out !== m_q) begin
        failures++;
        $display("FAIL rand_iq n=%0d: i=%0d q=%0d want %0d %0d",
                 n, $signed(i_out), $signed(q_out), m_i, m_q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arm_lock();
`ifndef FDOWN_SEQ_DECIM_EN
    test_pairing();
`else
    test_decim();
`endif
    test_fault();
    test_abort();
    test_guard();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
